// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared types for the Riviera writeback stage.
//   interconnection_struct : MEM-stage result bundle (only the fields that the
//                            writeback stage consumes are carried here)
//   wb_entry_t             : one retire-queue entry
//   make_entry()           : builds a queue entry from an incoming MEM result
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int ALEN_W       = 5;    // architectural register index width
    localparam int DATA_W       = 64;   // register data width
    localparam int WB_DEPTH_DEF = 2;    // default retire-queue depth

    typedef struct packed {
        logic              valid;
        logic              rf_wr_en;
        logic [ALEN_W-1:0] rf_wr_addr;
        logic [DATA_W-1:0] rf_wr_data;
    } interconnection_struct;

    typedef struct packed {
        logic [ALEN_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              needs_wr;
        logic              exc;
    } wb_entry_t;

    // Writes to x0 are architecturally discarded, and an excepting access
    // must never reach the register file, so both collapse to needs_wr = 0.
    function automatic wb_entry_t make_entry(
        input logic [ALEN_W-1:0] addr,
        input logic [DATA_W-1:0] data,
        input logic              wr_en,
        input logic              exc
    );
        wb_entry_t e;
        e.addr     = addr;
        e.data     = data;
        e.exc      = exc;
        e.needs_wr = wr_en && (addr != '0) && !exc;
        return e;
    endfunction

endpackage

// File: rtl/wb_retire_fifo.sv
// -----------------------------------------------------------------------------
// wb_retire_fifo
// In-order retire queue for the writeback stage. Holds all queue state:
// storage, per-entry valid bits, read/write pointers and occupancy count.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_push, i_entry  : enqueue i_entry (ignored while full)
//   i_pop            : dequeue the head (ignored while empty)
//   o_head           : oldest entry; o_head_valid qualifies it
//   o_fwd_valid      : some queued entry writes a register
//   o_fwd_addr/data  : destination/data of the youngest such entry (0 if none)
//   o_full, o_empty  : occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module wb_retire_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  wb_entry_t         i_entry,
    input  logic              i_pop,
    output wb_entry_t         o_head,
    output logic              o_head_valid,
    output logic              o_fwd_valid,
    output logic [ALEN_W-1:0] o_fwd_addr,
    output logic [DATA_W-1:0] o_fwd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full       = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_head_valid = r_vld[r_rd_ptr];
    assign o_head       = r_mem[r_rd_ptr];

    // A full queue refuses the push even if the head leaves this cycle, so
    // push and pop can never target the same slot.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && o_head_valid;

    // Control state: pointers, valid bits, count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_do_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is data only; validity lives in r_vld
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Walk backwards from the newest slot; valid entries form one contiguous
    // run ending at wr_ptr-1, so the first hit is the youngest writer.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found      = 1'b0;
        idx        = '0;
        o_fwd_addr = '0;
        o_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_wr_ptr - PTR_W'(i + 1);
            if (!found && r_vld[idx] && r_mem[idx].needs_wr) begin
                found      = 1'b1;
                o_fwd_addr = r_mem[idx].addr;
                o_fwd_data = r_mem[idx].data;
            end
        end
        o_fwd_valid = found;
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage of the Riviera pipeline. Accepts MEM-stage results into a
// small in-order retire queue and retires them in program order through the
// shared register-file write port.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_mem2all                   : MEM result (valid, rf_wr_en, addr, data)
//   i_load/store_miss_aligned_error : mark the current MEM result as excepting
//   i_rf_grant                  : register-file write port available
//   o_wb_ready                  : queue has room (registered count only)
//   o_rf_wr_en/addr/data        : register-file write port
//   o_fwd_valid/addr/data       : youngest queued register write (forwarding)
//   o_exception                 : one-cycle pulse when an excepting entry retires
//   o_instret                   : instructions retired without exception
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF,
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  interconnection_struct i_mem2all,
    input  logic                 i_load_miss_aligned_error,
    input  logic                 i_store_miss_aligned_error,
    input  logic                 i_rf_grant,
    output logic                 o_wb_ready,
    output logic                 o_rf_wr_en,
    output logic [ALEN_W-1:0]    o_rf_wr_addr,
    output logic [DATA_W-1:0]    o_rf_wr_data,
    output logic                 o_fwd_valid,
    output logic [ALEN_W-1:0]    o_fwd_addr,
    output logic [DATA_W-1:0]    o_fwd_data,
    output logic                 o_exception,
    output logic [CNT_W-1:0]     o_instret
);

    wb_entry_t        w_entry;
    wb_entry_t        w_head;
    logic             w_head_valid;
    logic             w_full;
    logic             w_empty;
    logic             w_exc_in;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_instret;

    // Accept
    assign w_exc_in = i_load_miss_aligned_error | i_store_miss_aligned_error;
    assign w_entry  = make_entry(i_mem2all.rf_wr_addr, i_mem2all.rf_wr_data,
                                 i_mem2all.rf_wr_en, w_exc_in);

    // Ready depends only on registered occupancy so MEM never sees a
    // combinational path from the register-file arbiter.
    assign o_wb_ready = !w_full;
    assign w_push     = i_mem2all.valid && !w_full;

    wb_retire_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_entry      (w_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_fwd_valid  (o_fwd_valid),
        .o_fwd_addr   (o_fwd_addr),
        .o_fwd_data   (o_fwd_data),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Retire: only real register writes wait for the port; excepting and
    // non-writing entries leave as soon as they reach the head.
    assign w_pop = w_head_valid && (w_head.exc || !w_head.needs_wr || i_rf_grant);

    assign o_rf_wr_en   = w_head_valid && w_head.needs_wr && i_rf_grant;
    assign o_rf_wr_addr = w_empty ? '0 : w_head.addr;
    assign o_rf_wr_data = w_empty ? '0 : w_head.data;

    // needs_wr is forced low for excepting entries, so this pulse and the
    // write strobe are mutually exclusive.
    assign o_exception  = w_pop && w_head.exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_pop && !w_head.exc) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign o_instret = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    interconnection_struct mem;
    logic lerr, serr, grant;
    logic              o_wb_ready, o_rf_wr_en, o_fwd_valid, o_exception;
    logic [ALEN_W-1:0] o_rf_wr_addr, o_fwd_addr;
    logic [DATA_W-1:0] o_rf_wr_data, o_fwd_data;
    logic [63:0]       o_instret;

    // Second instance: deeper queue, narrow counter for the wrap check
    interconnection_struct mem_w;
    logic              w_zero = 1'b0;
    logic              grant_w = 1'b1;
    logic              w_ready, w_wr_en, w_fwd_valid, w_exception;
    logic [ALEN_W-1:0] w_wr_addr, w_fwd_addr;
    logic [DATA_W-1:0] w_wr_data, w_fwd_data;
    logic [3:0]        w_instret;

    wb_stage #(.DEPTH(2), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .i_mem2all(mem),
        .i_load_miss_aligned_error(lerr), .i_store_miss_aligned_error(serr),
        .i_rf_grant(grant), .o_wb_ready(o_wb_ready), .o_rf_wr_en(o_rf_wr_en),
        .o_rf_wr_addr(o_rf_wr_addr), .o_rf_wr_data(o_rf_wr_data),
        .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr), .o_fwd_data(o_fwd_data),
        .o_exception(o_exception), .o_instret(o_instret)
    );

    wb_stage #(.DEPTH(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_mem2all(mem_w),
        .i_load_miss_aligned_error(w_zero), .i_store_miss_aligned_error(w_zero),
        .i_rf_grant(grant_w), .o_wb_ready(w_ready), .o_rf_wr_en(w_wr_en),
        .o_rf_wr_addr(w_wr_addr), .o_rf_wr_data(w_wr_data),
        .o_fwd_valid(w_fwd_valid), .o_fwd_addr(w_fwd_addr), .o_fwd_data(w_fwd_data),
        .o_exception(w_exception), .o_instret(w_instret)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [ALEN_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                nw;
        bit                exc;
    } ment_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wen, input logic [ALEN_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic le, input logic se);
        mem.valid      = v;
        mem.rf_wr_en   = wen;
        mem.rf_wr_addr = a;
        mem.rf_wr_data = d;
        lerr           = le;
        serr           = se;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        mem_w = '0;
        grant = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        mem_w = '0;
        grant = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        n_tests++;
        if ({o_rf_wr_en, o_fwd_valid, o_exception} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 000", {o_rf_wr_en, o_fwd_valid, o_exception});
        end
        n_tests++;
        if ({o_rf_wr_addr, o_rf_wr_data, o_fwd_addr, o_fwd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got wr %0h/%0h fwd %0h/%0h required 0",
                     o_rf_wr_addr, o_rf_wr_data, o_fwd_addr, o_fwd_data);
        end
        n_tests++;
        if (o_instret !== 64'd0 || w_instret !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_instret: got %0h/%0h required 0/0", o_instret, w_instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (o_wb_ready !== 1'b1 || w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b required 1/1", o_wb_ready, w_ready);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ALEN_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        do_reset();
        grant = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            if (k < 4) drive(1'b1, 1'b1, ALEN_W'(5 + k), DATA_W'(17 * (k + 1)), 1'b0, 1'b0);
            else       drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            #1;
            n_tests++;
            if (o_wb_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b required 1", k, o_wb_ready);
            end
            ea = ALEN_W'(4 + k);
            ed = DATA_W'(17 * k);
            n_tests++;
            if (k == 0) begin
                if (o_rf_wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_first_idle: got wr_en %b required 0", o_rf_wr_en);
                end
            end else if ({o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data} !== {1'b1, ea, ed}) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: got %b x%0d %0h required 1 x%0d %0h",
                         k, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, ea, ed);
            end
        end
        tick();
        n_tests++;
        if (o_instret !== 64'd4 || o_rf_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_instret: got %0d wr_en %b required 4 wr_en 0", o_instret, o_rf_wr_en);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 1'b1, 5'd1, 64'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd2, 64'hB, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_wb_ready, o_rf_wr_en, o_fwd_valid, o_fwd_addr} !== {1'b1, 1'b0, 1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL bp_one_queued: got rdy %b wr %b fwd %b x%0d required 1 0 1 x1",
                     o_wb_ready, o_rf_wr_en, o_fwd_valid, o_fwd_addr);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_wb_ready, o_rf_wr_en, o_fwd_addr, o_fwd_data} !== {1'b0, 1'b0, 5'd2, 64'hB}) begin
            n_fail++;
            $display("FAIL bp_full: got rdy %b wr %b fwd x%0d %0h required 0 0 x2 b",
                     o_wb_ready, o_rf_wr_en, o_fwd_addr, o_fwd_data);
        end
        tick();
        grant = 1'b1;
        #1;
        n_tests++;
        if ({o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_fwd_addr} !==
            {1'b0, 1'b1, 5'd1, 64'hA, 5'd2}) begin
            n_fail++;
            $display("FAIL bp_write_x1: got rdy %b wr %b x%0d %0h fwd x%0d required 0 1 x1 a fwd x2",
                     o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_fwd_addr);
        end
        tick();
        n_tests++;
        if ({o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_fwd_addr} !==
            {1'b1, 1'b1, 5'd2, 64'hB, 5'd2}) begin
            n_fail++;
            $display("FAIL bp_write_x2: got rdy %b wr %b x%0d %0h fwd x%0d required 1 1 x2 b fwd x2",
                     o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_fwd_addr);
        end
        tick();
        n_tests++;
        if ({o_rf_wr_en, o_fwd_valid} !== 2'b00 || o_instret !== 64'd2) begin
            n_fail++;
            $display("FAIL bp_drained: got wr %b fwd %b instret %0d required 0 0 2",
                     o_rf_wr_en, o_fwd_valid, o_instret);
        end
    endtask

    task automatic test_x0_nonwrite();
        do_reset();
        drive(1'b1, 1'b1, 5'd0, 64'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 5'd9, 64'h99, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_rf_wr_en, o_fwd_valid, o_exception} !== 3'b000) begin
            n_fail++;
            $display("FAIL x0_no_write: got wr %b fwd %b exc %b required 000",
                     o_rf_wr_en, o_fwd_valid, o_exception);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_rf_wr_en, o_fwd_valid} !== 2'b00 || o_instret !== 64'd1) begin
            n_fail++;
            $display("FAIL nonwrite_retire: got wr %b fwd %b instret %0d required 0 0 1",
                     o_rf_wr_en, o_fwd_valid, o_instret);
        end
        tick();
        n_tests++;
        if (o_instret !== 64'd2 || o_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_instret: got %0d rdy %b required 2 rdy 1", o_instret, o_wb_ready);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        drive(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd4, 64'h44, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_exception, o_rf_wr_en, o_fwd_valid} !== 3'b100 || o_instret !== 64'd0) begin
            n_fail++;
            $display("FAIL mis_exc_pulse: got exc %b wr %b fwd %b instret %0d required 1 0 0 0",
                     o_exception, o_rf_wr_en, o_fwd_valid, o_instret);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        grant = 1'b1;
        #1;
        n_tests++;
        if ({o_exception, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data} !== {1'b0, 1'b1, 5'd4, 64'h44}
            || o_instret !== 64'd0) begin
            n_fail++;
            $display("FAIL mis_next_write: got exc %b wr %b x%0d %0h instret %0d required 0 1 x4 44 0",
                     o_exception, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_instret);
        end
        tick();
        n_tests++;
        if (o_instret !== 64'd1 || o_exception !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_instret: got %0d exc %b required 1 exc 0", o_instret, o_exception);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        drive(1'b1, 1'b1, 5'd10, 64'hA0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd11, 64'hB0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd12, 64'hC0, 1'b0, 1'b0);
        grant = 1'b1;
        #1;
        n_tests++;
        if ({o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data} !== {1'b0, 1'b1, 5'd10, 64'hA0}) begin
            n_fail++;
            $display("FAIL full_pop_blocked: got rdy %b wr %b x%0d %0h required 0 1 x10 a0",
                     o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data);
        end
        tick();
        n_tests++;
        if ({o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_fwd_addr} !==
            {1'b1, 1'b1, 5'd11, 64'hB0, 5'd11}) begin
            n_fail++;
            $display("FAIL full_pop_after: got rdy %b wr %b x%0d %0h fwd x%0d required 1 1 x11 b0 x11",
                     o_wb_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_fwd_addr);
        end
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data} !== {1'b1, 5'd12, 64'hC0}) begin
            n_fail++;
            $display("FAIL full_pop_held: got wr %b x%0d %0h required 1 x12 c0",
                     o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data);
        end
        tick();
        n_tests++;
        if (o_rf_wr_en !== 1'b0 || o_instret !== 64'd3) begin
            n_fail++;
            $display("FAIL full_pop_count: got wr %b instret %0d required 0 3", o_rf_wr_en, o_instret);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        grant = 1'b1;
        drive(1'b1, 1'b1, 5'd1, 64'h1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        grant = 1'b0;
        drive(1'b1, 1'b1, 5'd2, 64'h2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd3, 64'h3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({o_wb_ready, o_fwd_valid, o_fwd_addr} !== {1'b0, 1'b1, 5'd3} || o_instret !== 64'd1) begin
            n_fail++;
            $display("FAIL arst_setup: got rdy %b fwd %b x%0d instret %0d required 0 1 x3 1",
                     o_wb_ready, o_fwd_valid, o_fwd_addr, o_instret);
        end
        #2 rst_n = 1'b0;
        grant = 1'b1;
        #1;
        n_tests++;
        if ({o_rf_wr_en, o_fwd_valid, o_exception, o_wb_ready} !== 4'b0001 || o_instret !== 64'd0 ||
            {o_rf_wr_addr, o_rf_wr_data, o_fwd_addr, o_fwd_data} !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate: got wr %b fwd %b exc %b rdy %b instret %0d addr %0d",
                     o_rf_wr_en, o_fwd_valid, o_exception, o_wb_ready, o_instret, o_rf_wr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if ({o_rf_wr_en, o_wb_ready} !== 2'b01 || o_instret !== 64'd0) begin
                n_fail++;
                $display("FAIL arst_after[%0d]: got wr %b rdy %b instret %0d required 0 1 0",
                         c, o_rf_wr_en, o_wb_ready, o_instret);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_w.valid      = 1'b1;
            mem_w.rf_wr_en   = 1'b0;
            mem_w.rf_wr_addr = ALEN_W'(i);
            mem_w.rf_wr_data = DATA_W'(i);
            tick();
        end
        mem_w = '0;
        #1;
        n_tests++;
        if (w_instret !== 4'hF) begin
            n_fail++;
            $display("FAIL wrap_max: got %0h required f", w_instret);
        end
        tick();
        n_tests++;
        if (w_instret !== 4'h0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %0h required 0", w_instret);
        end
    endtask

    task automatic test_random();
        ment_t             mq[$];
        ment_t             pend_ent;
        logic [63:0]       m_instret;
        bit                pend_pop, pend_push, hold, have, e_ready, e_pop, e_wr, e_exc, e_fv;
        logic [ALEN_W-1:0] e_wa, e_fa;
        logic [DATA_W-1:0] e_wd, e_fd;
        do_reset();
        m_instret = '0;
        pend_pop  = 0;
        pend_push = 0;
        hold      = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (pend_pop) begin
                if (!mq[0].exc) m_instret = m_instret + 64'd1;
                void'(mq.pop_front());
            end
            if (pend_push) mq.push_back(pend_ent);
            if (!hold) begin
                drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                      ALEN_W'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
                      {$urandom, $urandom}, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            end
            grant = ($urandom_range(0, 9) < 6);
            #1;
            have    = (mq.size() > 0);
            e_ready = (mq.size() != 2);
            e_pop   = have && (mq[0].exc || !mq[0].nw || grant);
            e_wr    = have && mq[0].nw && grant;
            e_exc   = e_pop && mq[0].exc;
            e_wa    = have ? mq[0].addr : '0;
            e_wd    = have ? mq[0].data : '0;
            e_fv    = 0;
            e_fa    = '0;
            e_fd    = '0;
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (!e_fv && mq[j].nw) begin
                    e_fv = 1;
                    e_fa = mq[j].addr;
                    e_fd = mq[j].data;
                end
            end
            n_tests++;
            if ({o_wb_ready, o_rf_wr_en, o_exception} !== {e_ready, e_wr, e_exc}) begin
                n_fail++;
                $display("FAIL rnd_ctrl[%0d]: got rdy/wr/exc %b%b%b required %b%b%b",
                         c, o_wb_ready, o_rf_wr_en, o_exception, e_ready, e_wr, e_exc);
            end
            n_tests++;
            if ({o_rf_wr_addr, o_rf_wr_data} !== {e_wa, e_wd}) begin
                n_fail++;
                $display("FAIL rnd_wr_port[%0d]: got x%0d %0h required x%0d %0h",
                         c, o_rf_wr_addr, o_rf_wr_data, e_wa, e_wd);
            end
            n_tests++;
            if ({o_fwd_valid, o_fwd_addr, o_fwd_data} !== {e_fv, e_fa, e_fd}) begin
                n_fail++;
                $display("FAIL rnd_fwd[%0d]: got %b x%0d %0h required %b x%0d %0h",
                         c, o_fwd_valid, o_fwd_addr, o_fwd_data, e_fv, e_fa, e_fd);
            end
            n_tests++;
            if (o_instret !== m_instret) begin
                n_fail++;
                $display("FAIL rnd_instret[%0d]: got %0d required %0d", c, o_instret, m_instret);
            end
            n_tests++;
            if (o_rf_wr_en === 1'b1 && o_exception === 1'b1) begin
                n_fail++;
                $display("FAIL rnd_exclusive[%0d]: got wr_en and exception both 1 required not both", c);
            end
            pend_pop      = e_pop;
            pend_push     = mem.valid && e_ready;
            pend_ent.addr = mem.rf_wr_addr;
            pend_ent.data = mem.rf_wr_data;
            pend_ent.exc  = lerr || serr;
            pend_ent.nw   = mem.rf_wr_en && (mem.rf_wr_addr != 0) && !(lerr || serr);
            hold          = mem.valid && !e_ready;
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        mem_w = '0;
        grant = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_x0_nonwrite();
        test_misaligned();
        test_full_pop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
